// File: rtl/frame_serializer.sv
// frame_serializer: valid/ready parallel word to framed serial line (start 0, data, stop 1).
module frame_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             frame_start
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic ser_q, ser_d, fs_q, fs_d;
  logic last, last_bit, head, hs;
  logic [WIDTH-1:0] sh_nxt;
  assign last = cyc_q == CW'(CLKS_PER_BIT - 1);
  assign last_bit = bit_q == BW'(WIDTH - 1);
  assign head = LSB_FIRST != 0 ? sh_q[0] : sh_q[WIDTH-1];
  assign sh_nxt = LSB_FIRST != 0 ? sh_q >> 1 : sh_q << 1;
  assign par_ready = state_q == IDLE || (state_q == STOP && last);
  assign hs = par_valid && par_ready;
  assign ser_out = ser_q;
  assign busy = state_q != IDLE;
  assign frame_start = fs_q;
  always_comb begin
    state_d = state_q;
    cyc_d = (state_q == IDLE || last) ? '0 : cyc_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    ser_d = ser_q;
    fs_d = hs;
    unique case (state_q)
      START: if (last) begin
        state_d = DATA;
        bit_d = '0;
        ser_d = head;
        sh_d = sh_nxt;
      end
      DATA: if (last) begin
        state_d = last_bit ? STOP : DATA;
        bit_d = last_bit ? bit_q : bit_q + BW'(1);
        ser_d = last_bit ? 1'b1 : head;
        sh_d = last_bit ? sh_q : sh_nxt;
      end
      STOP: if (last) state_d = IDLE;
      default: ;
    endcase
    // A handshake is only possible in IDLE or the final STOP cycle, so it overrides both.
    if (hs) begin
      state_d = START;
      sh_d = par_data;
      ser_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      ser_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      ser_q <= ser_d;
      fs_q <= fs_d;
    end
  end
endmodule
